// File: rtl/stream_pixel_unpacker.sv
// Receive side of the packed 24-bit RGB AXI-Stream: rebuilds one pixel per handshake
// from 4-pixels-per-3-words packing, tracks x/y/frame position and flags SOF/EOL framing errors.
module stream_pixel_unpacker #(
    parameter int unsigned X_SIZE = 640,
    parameter int unsigned Y_SIZE = 480
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] in_stream_tdata,
    input  logic [3:0]  in_stream_tkeep,
    input  logic        in_stream_tlast,
    input  logic        in_stream_tuser,
    input  logic        in_stream_tvalid,
    output logic        in_stream_tready,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        err_sof,
    output logic        err_eol
);

    typedef enum logic {HUNT, RUN} state_t;

    localparam logic [9:0] X_LAST     = 10'(X_SIZE - 1);
    localparam logic [9:0] X_EOL_WORD = 10'(X_SIZE - 2);
    localparam logic [8:0] Y_LAST     = 9'(Y_SIZE - 1);

    state_t      state, state_nxt;
    logic [1:0]  phase, phase_nxt, eff_phase;
    logic [9:0]  x, x_nxt, eff_x;
    logic [8:0]  y, y_nxt, eff_y;
    logic [23:0] residual, residual_nxt, res_new, pixel;
    logic        load_en, word_acc, restart, do_load, tlast_expected;
    logic        err_sof_nxt, err_eol_nxt, frame_done_nxt;
    logic [15:0] frame_count_nxt;
    logic        tkeep_unused;

    assign tkeep_unused     = ^in_stream_tkeep;
    assign load_en          = !pix_valid || pix_ready;
    assign in_stream_tready = (state == HUNT) || ((phase != 2'd3) && load_en);

    always_comb begin
        state_nxt       = state;
        phase_nxt       = phase;
        x_nxt           = x;
        y_nxt           = y;
        residual_nxt    = residual;
        pixel           = '0;
        res_new         = '0;

        word_acc = in_stream_tvalid && in_stream_tready;
        // A tuser word anywhere but the natural frame start re-anchors decoding at x=y=0, phase 0.
        restart  = word_acc && in_stream_tuser &&
                   ((state == HUNT) || (phase != 2'd0) || (x != '0) || (y != '0));
        eff_phase = restart ? 2'd0 : phase;
        eff_x     = restart ? '0 : x;
        eff_y     = restart ? '0 : y;

        if (state == HUNT)
            do_load = restart;
        else
            do_load = (phase == 2'd3) ? load_en : word_acc;

        case (eff_phase)
            2'd0: begin
                pixel   = in_stream_tdata[23:0];
                res_new = {16'h0000, in_stream_tdata[31:24]};
            end
            2'd1: begin
                pixel   = {in_stream_tdata[15:0], residual[7:0]};
                res_new = {8'h00, in_stream_tdata[31:16]};
            end
            2'd2: begin
                pixel   = {in_stream_tdata[7:0], residual[15:0]};
                res_new = in_stream_tdata[31:8];
            end
            default: begin
                pixel   = residual;
                res_new = residual;
            end
        endcase

        if (do_load) begin
            state_nxt    = RUN;
            phase_nxt    = eff_phase + 2'd1;
            residual_nxt = res_new;
            if (eff_x == X_LAST) begin
                x_nxt = '0;
                y_nxt = (eff_y == Y_LAST) ? '0 : eff_y + 9'd1;
            end else begin
                x_nxt = eff_x + 10'd1;
                y_nxt = eff_y;
            end
        end

        tlast_expected  = (eff_phase == 2'd2) && (eff_x == X_EOL_WORD);
        err_sof_nxt     = err_sof || (restart && (state == RUN));
        err_eol_nxt     = err_eol || (word_acc && (state == RUN) && (in_stream_tlast != tlast_expected));
        frame_done_nxt  = pix_valid && pix_ready && (pix_x == X_LAST) && (pix_y == Y_LAST);
        frame_count_nxt = frame_count + 16'(frame_done_nxt);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state       <= HUNT;
            phase       <= '0;
            x           <= '0;
            y           <= '0;
            residual    <= '0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_sof     <= 1'b0;
            pix_eol     <= 1'b0;
            pix_valid   <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            err_sof     <= 1'b0;
            err_eol     <= 1'b0;
        end else begin
            state       <= state_nxt;
            phase       <= phase_nxt;
            x           <= x_nxt;
            y           <= y_nxt;
            residual    <= residual_nxt;
            frame_done  <= frame_done_nxt;
            frame_count <= frame_count_nxt;
            err_sof     <= err_sof_nxt;
            err_eol     <= err_eol_nxt;
            if (do_load) begin
                r         <= pixel[23:16];
                g         <= pixel[15:8];
                b         <= pixel[7:0];
                pix_x     <= eff_x;
                pix_y     <= eff_y;
                pix_sof   <= (eff_x == '0) && (eff_y == '0);
                pix_eol   <= (eff_x == X_LAST);
                pix_valid <= 1'b1;
            end else if (pix_ready) begin
                pix_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_pixel_unpacker.sv
// Bench for stream_pixel_unpacker: scenario table plus random frames checked against a
// byte-queue reference decoder, with a hand-written mid-line reset sequence.
module tb_stream_pixel_unpacker;

    localparam int XS  = 8;
    localparam int YS  = 2;
    localparam int WPL = XS * 3 / 4;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] in_stream_tdata;
    logic [3:0]  in_stream_tkeep;
    logic        in_stream_tlast, in_stream_tuser, in_stream_tvalid, in_stream_tready;
    logic [7:0]  r, g, b;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        pix_sof, pix_eol, pix_valid, pix_ready, frame_done, err_sof, err_eol;
    logic [15:0] frame_count;

    always #5 aclk = ~aclk;

    stream_pixel_unpacker #(.X_SIZE(XS), .Y_SIZE(YS)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .in_stream_tdata(in_stream_tdata), .in_stream_tkeep(in_stream_tkeep),
        .in_stream_tlast(in_stream_tlast), .in_stream_tuser(in_stream_tuser),
        .in_stream_tvalid(in_stream_tvalid), .in_stream_tready(in_stream_tready),
        .r(r), .g(g), .b(b), .pix_x(pix_x), .pix_y(pix_y),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .frame_done(frame_done), .frame_count(frame_count),
        .err_sof(err_sof), .err_eol(err_eol)
    );

    typedef struct packed { logic [31:0] d; logic u; logic l; } word_t;
    typedef struct packed { logic [23:0] p; logic [9:0] x; logic [8:0] y; logic sof; logic eol; } pix_t;
    typedef struct {
        string name;
        int    ready_mode;
        int    garbage;
        int    n_frames;
        bit    rand_pix;
        int    tuser_word;
        int    notlast_word;
        int    gap;
        int    sof_idx;
        int    exp_pix;
        int    exp_frames;
        bit    exp_sof;
        bit    exp_eol;
    } vec_t;

    int    checks = 0;
    int    failures = 0;
    int    timeouts = 0;
    int    ready_mode = 0;
    int    rdy_cnt = 0;
    int    fd_count = 0, fd_bad = 0, hold_viol = 0, tready_viol = 0;
    pix_t  got[$];
    pix_t  exp_q[$];
    word_t sent[$];
    word_t plan[$];
    bit    m_sof, m_eol;
    int    m_frames;
    pix_t  cur, prev_pix;
    bit    prev_stall = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Downstream ready: 0 = always, 1 = repeating 1-0-0-1, other = random (75% high)
    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge aclk); #1;
            rdy_cnt++;
            case (ready_mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = (rdy_cnt % 4 == 0) || (rdy_cnt % 4 == 3);
                default: pix_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    always @(negedge aclk) begin
        cur = '{p: {r, g, b}, x: pix_x, y: pix_y, sof: pix_sof, eol: pix_eol};
        if (aresetn) begin
            if (frame_done) begin
                fd_count++;
                if (got.size() == 0 || got[got.size()-1].x != 10'(XS-1) || got[got.size()-1].y != 9'(YS-1))
                    fd_bad++;
            end
            if (prev_stall && (!pix_valid || cur != prev_pix)) hold_viol++;
            if (pix_valid && !pix_ready && in_stream_tready) tready_viol++;
            if (pix_valid && pix_ready) got.push_back(cur);
            prev_stall = pix_valid && !pix_ready;
            prev_pix   = cur;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge aclk); #1; end
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        in_stream_tvalid = 1'b0;
        idle(2);
        aresetn = 1'b1;
    endtask

    task automatic send_word(input word_t w);
        int n = 0;
        bit acc = 0;
        in_stream_tdata  = w.d;
        in_stream_tuser  = w.u;
        in_stream_tlast  = w.l;
        in_stream_tvalid = 1'b1;
        while (!acc && n < 500) begin
            @(negedge aclk);
            acc = in_stream_tready;
            @(posedge aclk); #1;
            n++;
        end
        in_stream_tvalid = 1'b0;
        if (acc) sent.push_back(w);
        else timeouts++;
    endtask

    // Packer: pixel bytes low-first onto the wire, words filled from lane 0 upward
    task automatic add_frame(input bit rand_pix);
        logic [7:0]  bytes[$];
        logic [23:0] p;
        word_t       w;
        for (int i = 0; i < XS * YS; i++) begin
            p = rand_pix ? 24'($urandom) : 24'(i + 1);
            bytes.push_back(p[7:0]);
            bytes.push_back(p[15:8]);
            bytes.push_back(p[23:16]);
        end
        for (int k = 0; k < bytes.size() / 4; k++) begin
            w.d = {bytes[4*k+3], bytes[4*k+2], bytes[4*k+1], bytes[4*k]};
            w.u = (k == 0);
            w.l = (k % WPL == WPL - 1);
            plan.push_back(w);
        end
    endtask

    // Reference decoder over the accepted byte stream
    task automatic run_model(input int base);
        logic [7:0] q[$];
        bit   hunting = 1;
        bit   was_hunting;
        int   idx = 0;
        pix_t e;
        exp_q.delete();
        m_sof = 0; m_eol = 0; m_frames = 0;
        for (int i = base; i < sent.size(); i++) begin
            if (hunting && !sent[i].u) continue;
            was_hunting = hunting;
            if (sent[i].u && (hunting || q.size() != 0 || idx != 0)) begin
                if (!hunting) m_sof = 1;
                q.delete();
                idx = 0;
            end
            hunting = 0;
            for (int k = 0; k < 4; k++) q.push_back(sent[i].d[8*k +: 8]);
            while (q.size() >= 3) begin
                e.p   = {q[2], q[1], q[0]};
                repeat (3) void'(q.pop_front());
                e.x   = 10'(idx % XS);
                e.y   = 9'(idx / XS);
                e.sof = (idx == 0);
                e.eol = (idx % XS == XS - 1);
                exp_q.push_back(e);
                if (idx == XS * YS - 1) m_frames++;
                idx = (idx + 1) % (XS * YS);
            end
            if (!was_hunting && sent[i].l != (q.size() == 0 && idx % XS == 0)) m_eol = 1;
        end
    endtask

    task automatic check_stream(input string name, input int sb, input int gb, input int fb,
                                input int hb, input int tb0, input int fbb, input int tmo);
        int n = 0;
        int bad = 0;
        int first = -1;
        run_model(sb);
        while (got.size() - gb < exp_q.size() && n < 2000) begin idle(1); n++; end
        idle(3);
        check({name, " pixel count"}, got.size() - gb, exp_q.size());
        for (int i = 0; i < exp_q.size() && gb + i < got.size(); i++)
            if (got[gb+i] != exp_q[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        if (bad != 0)
            $display("  %s first differing pixel %0d: got %h expected %h", name, first, got[gb+first], exp_q[first]);
        check({name, " pixel mismatches"}, bad, 0);
        check({name, " frame_count"}, frame_count, m_frames);
        check({name, " frame_done pulses"}, fd_count - fb, m_frames);
        check({name, " frame_done misplaced"}, fd_bad - fbb, 0);
        check({name, " err_sof"}, err_sof, m_sof);
        check({name, " err_eol"}, err_eol, m_eol);
        check({name, " hold violations"}, hold_viol - hb, 0);
        check({name, " tready while stalled"}, tready_viol - tb0, 0);
        check({name, " send timeouts"}, timeouts - tmo, 0);
    endtask

    task automatic run_case(input vec_t v);
        int sb, gb, fb, hb, tb0, fbb, tmo;
        do_reset();
        ready_mode = v.ready_mode;
        sb = sent.size(); gb = got.size(); fb = fd_count; hb = hold_viol;
        tb0 = tready_viol; fbb = fd_bad; tmo = timeouts;
        plan.delete();
        for (int i = 0; i < v.garbage; i++) plan.push_back('{d: $urandom, u: 1'b0, l: 1'($urandom)});
        for (int f = 0; f < v.n_frames; f++) add_frame(v.rand_pix);
        if (v.tuser_word >= 0)   plan[v.garbage + v.tuser_word].u = 1'b1;
        if (v.notlast_word >= 0) plan[v.garbage + v.notlast_word].l = 1'b0;
        for (int i = 0; i < plan.size(); i++) begin
            if (v.garbage > 0 && i == v.garbage) begin
                idle(2);
                check({v.name, " garbage produced pixels"}, got.size() - gb, 0);
                check({v.name, " pix_valid after garbage"}, pix_valid, 0);
            end
            send_word(plan[i]);
            if (v.notlast_word >= 0 && i == v.garbage + v.notlast_word)
                check({v.name, " err_eol after missing tlast"}, err_eol, 1);
            if (v.gap > 0) idle($urandom_range(0, v.gap));
        end
        check_stream(v.name, sb, gb, fb, hb, tb0, fbb, tmo);
        check({v.name, " table pixel count"}, got.size() - gb, v.exp_pix);
        check({v.name, " table frame_count"}, frame_count, v.exp_frames);
        check({v.name, " table err_sof"}, err_sof, v.exp_sof);
        check({v.name, " table err_eol"}, err_eol, v.exp_eol);
        if (v.sof_idx >= 0 && gb + v.sof_idx < got.size())
            check({v.name, " restart pixel x/y/sof"},
                  {got[gb+v.sof_idx].x, got[gb+v.sof_idx].y, got[gb+v.sof_idx].sof}, {10'd0, 9'd0, 1'b1});
    endtask

    initial begin
        vec_t tbl[7];
        int sb, gb, fb, hb, tb0, fbb, tmo;
        //         name       rdy garb frm rnd tusr nolast gap sofi pix frm sof eol
        tbl[0] = '{"basic",    0,  0,   1,  0,  -1,  -1,    0, -1,  16, 1,  0,  0};
        tbl[1] = '{"toggle",   1,  0,   1,  0,  -1,  -1,    0, -1,  16, 1,  0,  0};
        tbl[2] = '{"garbage",  0,  5,   1,  0,  -1,  -1,    0, -1,  16, 1,  0,  0};
        tbl[3] = '{"no_tlast", 0,  0,   1,  0,  -1,   5,    0, -1,  16, 1,  0,  1};
        tbl[4] = '{"mid_sof",  0,  0,   1,  0,   4,  -1,    0,  5,  15, 0,  1,  1};
        tbl[5] = '{"rand3",    2,  3,   3,  1,  -1,  -1,    2, -1,  48, 3,  0,  0};
        tbl[6] = '{"rand_tog", 1,  0,   2,  1,  -1,  -1,    1, -1,  32, 2,  0,  0};

        in_stream_tkeep  = 4'hF;
        in_stream_tdata  = '0;
        in_stream_tuser  = 1'b0;
        in_stream_tlast  = 1'b0;
        in_stream_tvalid = 1'b0;
        do_reset();
        check("reset pix_valid", pix_valid, 0);
        check("reset frame_count", frame_count, 0);

        for (int i = 0; i < 7; i++) run_case(tbl[i]);

        // Reset mid-line at x=5 after a frame that left err_eol set and frame_count=1
        do_reset();
        ready_mode = 0;
        plan.delete();
        add_frame(0);
        plan[5].l = 1'b0;
        add_frame(0);
        for (int i = 0; i < 2 * WPL + 5; i++) send_word(plan[i]);
        check("pre-reset pix_x", {pix_valid, pix_x}, {1'b1, 10'd5});
        check("pre-reset frame_count", frame_count, 1);
        check("pre-reset err_eol", err_eol, 1);
        aresetn = 1'b0;
        idle(1);
        aresetn = 1'b1;
        check("mid reset pix_valid", pix_valid, 0);
        check("mid reset coords", {pix_x, pix_y}, 19'd0);
        check("mid reset counters", {frame_count, frame_done}, 17'd0);
        check("mid reset flags", {err_sof, err_eol}, 2'b00);
        check("mid reset rgb", {r, g, b}, 24'd0);

        sb = sent.size(); gb = got.size(); fb = fd_count; hb = hold_viol;
        tb0 = tready_viol; fbb = fd_bad; tmo = timeouts;
        for (int i = 0; i < 4; i++) send_word('{d: $urandom, u: 1'b0, l: 1'b0});
        idle(2);
        check("post reset hunt pixels", got.size() - gb, 0);
        plan.delete();
        add_frame(0);
        for (int i = 0; i < plan.size(); i++) send_word(plan[i]);
        check_stream("post reset frame", sb, gb, fb, hb, tb0, fbb, tmo);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
